writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL have one parameter: LOAD_TIMEOUT, default 15, the maximum number of cycles spent waiting for load data.
REQ-002 The block SHALL have a single clock and a synchronous, active-high reset; widths SHALL use `DWIDTH` = 32 and `AWIDTH` = 5.
REQ-003 wb_clk  input  1  clock; all state updates on the rising edge.
REQ-004 wb_rst  input  1  synchronous, active-high reset.
REQ-005 wb_i_ce  input  1  instruction valid from the memory stage.
REQ-006 wb_i_reg_wr  input  1  instruction writes the register file.
REQ-007 wb_i_memtoreg  input  1  result comes from load data.
REQ-008 wb_i_jal  input  1  link write; overrides memtoreg.
REQ-009 wb_i_addr_rd  input  AWIDTH  destination register.
REQ-010 wb_i_alu_value  input  DWIDTH  ALU result.
REQ-011 wb_i_pc  input  DWIDTH  address of the instruction.
REQ-012 wb_i_load_valid  input  1  load data valid strobe from data memory.
REQ-013 wb_i_load_data  input  DWIDTH  load data, sampled only when wb_i_load_valid=1.
REQ-014 wb_o_stall  output  1  hold upstream; high exactly while the state is WAIT_LOAD.
REQ-015 wb_o_reg_wr  output  1  register-file write enable (drives the decode-stage write port), 1-cycle pulse.
REQ-016 wb_o_addr_rd  output  AWIDTH  register-file write address.
REQ-017 wb_o_data_rd  output  DWIDTH  register-file write data.
REQ-018 wb_o_ce  output  1  instruction retired, 1-cycle pulse.
REQ-019 wb_o_timeout  output  1  load timeout, 1-cycle pulse.

Function
REQ-020 The FSM SHALL have two states, IDLE and WAIT_LOAD; all outputs SHALL be registered; latency from accept to the write pulse SHALL be 1 cycle.
REQ-021 In IDLE, an instruction with wb_i_ce=1 SHALL be accepted; with wb_i_ce=0, the outputs wb_o_reg_wr, wb_o_ce and wb_o_timeout SHALL be 0 the next cycle.
REQ-022 Jal accept (wb_i_jal=1): the next cycle SHALL have addr=31, data=wb_i_pc+8 (mod 2^32), reg_wr=1, ce=1, regardless of wb_i_memtoreg and wb_i_reg_wr.
REQ-023 Non-load accept (memtoreg=0, jal=0): the next cycle SHALL have data=wb_i_alu_value, addr=wb_i_addr_rd, ce=1, reg_wr=wb_i_reg_wr & (wb_i_addr_rd!=0).
REQ-024 Load accept with wb_i_load_valid=1 in the same cycle SHALL complete like REQ-023 but with data=wb_i_load_data, without entering WAIT_LOAD.
REQ-025 Load accept with wb_i_load_valid=0 SHALL latch reg_wr, addr_rd and the $0 qualification, clear the wait counter to 0, and enter WAIT_LOAD.
REQ-026 In WAIT_LOAD, wb_i_ce SHALL be ignored, because upstream holds while stalled.
REQ-027 In WAIT_LOAD, wb_i_load_valid=1 SHALL write the latched addr with wb_i_load_data on the next cycle (ce=1, reg_wr per REQ-023 qualification) and return to IDLE.
REQ-028 In WAIT_LOAD, wb_i_load_valid=0 SHALL increment the wait counter.
REQ-029 When the counter equals LOAD_TIMEOUT-1 and wb_i_load_valid=0, the block SHALL emit wb_o_timeout=1 the next cycle with reg_wr=0 and ce=0, drop the write, and return to IDLE.
REQ-030 If wb_i_load_valid arrives on the timeout cycle, the valid SHALL win and the write SHALL complete normally.
REQ-031 wb_i_load_valid while in IDLE with no load accepted that cycle SHALL be ignored.
REQ-032 wb_o_addr_rd and wb_o_data_rd SHALL hold their last values when reg_wr=0, except on reset.
REQ-033 The wait counter SHALL be wide enough for LOAD_TIMEOUT and SHALL never wrap.

Reset
REQ-034 wb_rst=1 SHALL force IDLE, counter=0, and all outputs to 0 (stall, reg_wr, ce, timeout, addr_rd=0, data_rd=0) at the next edge.
REQ-035 Reset asserted in WAIT_LOAD SHALL abandon the pending load with no write and no timeout pulse.
REQ-036 Reset SHALL take priority over all other inputs.

Verification
REQ-037 ALU write: ce=1, reg_wr=1, rd=5, alu=0x0000_1234 -> next cycle reg_wr=1, addr=5, data=0x0000_1234, ce=1, stall=0.
REQ-038 $0 suppression: rd=0, reg_wr=1, alu=0xFFFF_FFFF -> next cycle ce=1, reg_wr=0.
REQ-039 Jal: jal=1, pc=0x0040_0010 -> next cycle addr=31, data=0x0040_0018, reg_wr=1.
REQ-040 Delayed load: memtoreg=1, rd=8, load_valid=0, then load_valid=1 with data 0xCAFE_F00D on the 3rd wait cycle -> stall high for 3 cycles, then reg_wr=1, addr=8, data=0xCAFE_F00D, stall=0.
REQ-041 Timeout: LOAD_TIMEOUT=4, load never valid -> stall high for 4 cycles, then timeout=1, reg_wr=0, ce=0, then IDLE; also load_valid on the 4th wait cycle -> normal write, timeout=0.
REQ-042 Reset mid-wait: enter WAIT_LOAD, assert wb_rst for 1 cycle, then load_valid=1 -> all outputs 0, no write occurs.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: selects ALU, load or link data for the register-file write port,
// and stalls upstream while a load's data has not yet arrived (bounded by LOAD_TIMEOUT).
module writeback_stage #(
    parameter int unsigned LOAD_TIMEOUT = 15
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        wb_i_ce,
    input  logic        wb_i_reg_wr,
    input  logic        wb_i_memtoreg,
    input  logic        wb_i_jal,
    input  logic [4:0]  wb_i_addr_rd,
    input  logic [31:0] wb_i_alu_value,
    input  logic [31:0] wb_i_pc,
    input  logic        wb_i_load_valid,
    input  logic [31:0] wb_i_load_data,
    output logic        wb_o_stall,
    output logic        wb_o_reg_wr,
    output logic [4:0]  wb_o_addr_rd,
    output logic [31:0] wb_o_data_rd,
    output logic        wb_o_ce,
    output logic        wb_o_timeout
);

    localparam int unsigned DWIDTH = 32;
    localparam int unsigned AWIDTH = 5;
    localparam int unsigned CWIDTH = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [AWIDTH-1:0] LINK_REG = AWIDTH'(31);
    localparam logic [CWIDTH-1:0] LAST_WAIT = CWIDTH'(LOAD_TIMEOUT - 1);

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_WAIT_LOAD = 1'b1
    } state_t;

    state_t              r_state;
    logic [CWIDTH-1:0]   r_wait_cnt;
    logic                r_pend_wr;
    logic [AWIDTH-1:0]   r_pend_addr;
    logic                r_stall;
    logic                r_reg_wr;
    logic [AWIDTH-1:0]   r_addr_rd;
    logic [DWIDTH-1:0]   r_data_rd;
    logic                r_ce;
    logic                r_timeout;

    logic                w_wr_qual;
    logic [DWIDTH-1:0]   w_link_value;
    logic [DWIDTH-1:0]   w_result;
    logic                w_last_wait;

    // Writes to $0 are never performed, but the instruction still retires.
    assign w_wr_qual    = wb_i_reg_wr & (wb_i_addr_rd != '0);
    assign w_link_value = wb_i_pc + DWIDTH'(8);
    assign w_result     = wb_i_memtoreg ? wb_i_load_data : wb_i_alu_value;
    assign w_last_wait  = (r_wait_cnt == LAST_WAIT);

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_pend_wr   <= 1'b0;
            r_pend_addr <= '0;
            r_stall     <= 1'b0;
            r_reg_wr    <= 1'b0;
            r_addr_rd   <= '0;
            r_data_rd   <= '0;
            r_ce        <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_reg_wr  <= 1'b0;
            r_ce      <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wb_i_ce) begin
                        if (wb_i_jal) begin
                            r_ce      <= 1'b1;
                            r_reg_wr  <= 1'b1;
                            r_addr_rd <= LINK_REG;
                            r_data_rd <= w_link_value;
                        end else if (!wb_i_memtoreg || wb_i_load_valid) begin
                            r_ce     <= 1'b1;
                            r_reg_wr <= w_wr_qual;
                            if (w_wr_qual) begin
                                r_addr_rd <= wb_i_addr_rd;
                                r_data_rd <= w_result;
                            end
                        end else begin
                            // Load data not here yet: remember the destination and wait.
                            r_pend_wr   <= w_wr_qual;
                            r_pend_addr <= wb_i_addr_rd;
                            r_wait_cnt  <= '0;
                            r_stall     <= 1'b1;
                            r_state     <= S_WAIT_LOAD;
                        end
                    end
                end
                S_WAIT_LOAD: begin
                    if (wb_i_load_valid) begin
                        r_ce     <= 1'b1;
                        r_reg_wr <= r_pend_wr;
                        if (r_pend_wr) begin
                            r_addr_rd <= r_pend_addr;
                            r_data_rd <= wb_i_load_data;
                        end
                        r_stall <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_last_wait) begin
                        r_timeout <= 1'b1;
                        r_stall   <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CWIDTH'(1);
                    end
                end
                default: begin
                    r_stall <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wb_o_stall   = r_stall;
    assign wb_o_reg_wr  = r_reg_wr;
    assign wb_o_addr_rd = r_addr_rd;
    assign wb_o_data_rd = r_data_rd;
    assign wb_o_ce      = r_ce;
    assign wb_o_timeout = r_timeout;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the stage.
module tb_writeback_stage;

    localparam int LT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_ce, i_reg_wr, i_memtoreg, i_jal, i_lv;
    logic [4:0]  i_rd;
    logic [31:0] i_alu, i_pc, i_ld;
    logic        o_stall, o_reg_wr, o_ce, o_timeout;
    logic [4:0]  o_addr;
    logic [31:0] o_data;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: "a load is outstanding" plus how long it has waited.
    bit          m_waiting = 0;
    int          m_waited  = 0;
    bit          m_pend_wr = 0;
    logic [4:0]  m_pend_rd = '0;
    logic        e_stall = 0, e_reg_wr = 0, e_ce = 0, e_timeout = 0;
    logic [4:0]  e_addr = '0;
    logic [31:0] e_data = '0;

    writeback_stage #(.LOAD_TIMEOUT(LT)) dut (
        .wb_clk          (clk),
        .wb_rst          (rst),
        .wb_i_ce         (i_ce),
        .wb_i_reg_wr     (i_reg_wr),
        .wb_i_memtoreg   (i_memtoreg),
        .wb_i_jal        (i_jal),
        .wb_i_addr_rd    (i_rd),
        .wb_i_alu_value  (i_alu),
        .wb_i_pc         (i_pc),
        .wb_i_load_valid (i_lv),
        .wb_i_load_data  (i_ld),
        .wb_o_stall      (o_stall),
        .wb_o_reg_wr     (o_reg_wr),
        .wb_o_addr_rd    (o_addr),
        .wb_o_data_rd    (o_data),
        .wb_o_ce         (o_ce),
        .wb_o_timeout    (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic ce, input logic rwr, input logic m2r,
                         input logic jal, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] pc, input logic lv, input logic [31:0] ld);
        rst = r; i_ce = ce; i_reg_wr = rwr; i_memtoreg = m2r; i_jal = jal;
        i_rd = rd; i_alu = alu; i_pc = pc; i_lv = lv; i_ld = ld;
    endtask

    // Expected outputs after the coming edge, derived from the stage's rules.
    task automatic model_step();
        bit wr;
        e_reg_wr = 0; e_ce = 0; e_timeout = 0;
        if (rst) begin
            m_waiting = 0; m_waited = 0;
            e_stall = 0; e_addr = '0; e_data = '0;
        end else if (!m_waiting) begin
            if (i_ce) begin
                wr = i_reg_wr && (i_rd != 0);
                if (i_jal) begin
                    e_ce = 1; e_reg_wr = 1; e_addr = 5'd31; e_data = i_pc + 32'd8;
                end else if (!i_memtoreg || i_lv) begin
                    e_ce = 1; e_reg_wr = wr;
                    if (wr) begin
                        e_addr = i_rd;
                        e_data = i_memtoreg ? i_ld : i_alu;
                    end
                end else begin
                    m_waiting = 1; m_waited = 0; m_pend_wr = wr; m_pend_rd = i_rd;
                    e_stall = 1;
                end
            end
        end else begin
            m_waited++;
            if (i_lv) begin
                e_ce = 1; e_reg_wr = m_pend_wr;
                if (m_pend_wr) begin
                    e_addr = m_pend_rd; e_data = i_ld;
                end
                m_waiting = 0; e_stall = 0;
            end else if (m_waited == LT) begin
                e_timeout = 1; m_waiting = 0; e_stall = 0;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("stall",   32'(o_stall),   32'(e_stall));
        check("reg_wr",  32'(o_reg_wr),  32'(e_reg_wr));
        check("ce",      32'(o_ce),      32'(e_ce));
        check("timeout", 32'(o_timeout), 32'(e_timeout));
        check("addr_rd", 32'(o_addr),    32'(e_addr));
        check("data_rd", o_data,         e_data);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        // Reset state
        drive(1, 1, 1, 0, 0, 5'd3, 32'hDEAD_BEEF, 32'h0, 1, 32'h1);
        cycle();
        cycle();
        check("rst_data", o_data, 32'h0);

        // ALU write
        drive(0, 1, 1, 0, 0, 5'd5, 32'h0000_1234, 32'h0, 0, 32'h0);
        cycle();
        check("alu_data", o_data, 32'h0000_1234);
        check("alu_addr", 32'(o_addr), 32'd5);

        // $0 suppression: retires, no write, data/addr hold
        drive(0, 1, 1, 0, 0, 5'd0, 32'hFFFF_FFFF, 32'h0, 0, 32'h0);
        cycle();
        check("r0_wr", 32'(o_reg_wr), 32'd0);
        check("r0_hold", o_data, 32'h0000_1234);

        // Jal overrides memtoreg and reg_wr
        drive(0, 1, 0, 1, 1, 5'd7, 32'h1, 32'h0040_0010, 0, 32'h0);
        cycle();
        check("jal_addr", 32'(o_addr), 32'd31);
        check("jal_data", o_data, 32'h0040_0018);

        // Delayed load, data on the third wait cycle
        drive(0, 1, 1, 1, 0, 5'd8, 32'h0, 32'h0, 0, 32'h0);
        cycle();
        idle(); cycle();
        i_ce = 1; cycle();
        idle(); i_lv = 1; i_ld = 32'hCAFE_F00D; cycle();
        check("dload_data", o_data, 32'hCAFE_F00D);
        check("dload_addr", 32'(o_addr), 32'd8);
        check("dload_stall", 32'(o_stall), 32'd0);

        // Timeout after LT wait cycles
        drive(0, 1, 1, 1, 0, 5'd9, 32'h0, 32'h0, 0, 32'h0);
        cycle();
        idle();
        repeat (LT - 1) cycle();
        check("to_stall_before", 32'(o_stall), 32'd1);
        cycle();
        check("to_pulse", 32'(o_timeout), 32'd1);
        cycle();
        check("to_clear", 32'(o_timeout), 32'd0);

        // Valid on the timeout cycle wins
        drive(0, 1, 1, 1, 0, 5'd10, 32'h0, 32'h0, 0, 32'h0);
        cycle();
        idle();
        repeat (LT - 1) cycle();
        i_lv = 1; i_ld = 32'h1357_9BDF;
        cycle();
        check("late_data", o_data, 32'h1357_9BDF);
        check("late_to", 32'(o_timeout), 32'd0);

        // Reset mid-wait abandons the load
        drive(0, 1, 1, 1, 0, 5'd11, 32'h0, 32'h0, 0, 32'h0);
        cycle();
        idle(); cycle();
        rst = 1; i_lv = 1; i_ld = 32'h5555_AAAA;
        cycle();
        rst = 0;
        cycle();
        check("rstw_wr", 32'(o_reg_wr), 32'd0);
        check("rstw_data", o_data, 32'h0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 70,
                  $urandom_range(0, 99) < 80,
                  $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 15,
                  5'($urandom_range(0, 31)),
                  $urandom, $urandom,
                  $urandom_range(0, 99) < 30,
                  $urandom);
            if ($urandom_range(0, 9) == 0) i_rd = 5'd0;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
